// File: rtl/alu_flags_unit.sv
// alu_flags_unit: architectural Z/C/N status register with a flag-snapshot LIFO
// and jump-condition evaluation against the registered flags.
package arch_defs_pkg;
    localparam int DATA_WIDTH = 8;
endpackage

module alu_flags_unit
    import arch_defs_pkg::*;
#(
    parameter int STACK_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       alu_zero_in,
    input  logic       alu_carry_in,
    input  logic       alu_negative_in,
    input  logic       load_flags,
    input  logic       flags_push,
    input  logic       flags_pop,
    input  logic [2:0] cond_sel,
    output logic       flag_zero,
    output logic       flag_carry,
    output logic       flag_negative,
    output logic       branch_taken,
    output logic       stack_empty,
    output logic       stack_full,
    output logic       stack_error
);
    localparam int CW = $clog2(STACK_DEPTH + 1);
    localparam int IW = $clog2(STACK_DEPTH);

    logic [CW-1:0] r_count;
    logic [2:0]    r_flags;
    logic          r_err;
    logic [2:0]    r_mem [STACK_DEPTH];
    logic          w_push_ok;
    logic          w_pop_ok;
    logic          w_err_evt;
    logic [IW-1:0] w_wr_idx;
    logic [IW-1:0] w_rd_idx;

    assign stack_empty = (r_count == '0);
    assign stack_full  = (r_count == CW'(STACK_DEPTH));
    // push and pop together is an error, so neither takes effect
    assign w_push_ok = flags_push & ~flags_pop & ~stack_full;
    assign w_pop_ok  = flags_pop & ~flags_push & ~stack_empty;
    assign w_err_evt = (flags_push & flags_pop) | (flags_push & stack_full) | (flags_pop & stack_empty);
    assign w_wr_idx  = IW'(r_count);
    assign w_rd_idx  = IW'(r_count - CW'(1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
            r_flags <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= r_err | w_err_evt;
            if (w_push_ok)
                r_count <= r_count + CW'(1);
            else if (w_pop_ok)
                r_count <= r_count - CW'(1);
            if (w_pop_ok)
                r_flags <= r_mem[w_rd_idx];
            else if (load_flags)
                r_flags <= {alu_negative_in, alu_carry_in, alu_zero_in};
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok)
            r_mem[w_wr_idx] <= r_flags;
    end

    assign flag_negative = r_flags[2];
    assign flag_carry    = r_flags[1];
    assign flag_zero     = r_flags[0];
    assign stack_error   = r_err;

    always_comb begin
        branch_taken = 1'b0;
        case (cond_sel)
            3'b000: branch_taken = 1'b1;
            3'b001: branch_taken = flag_zero;
            3'b010: branch_taken = ~flag_zero;
            3'b011: branch_taken = flag_carry;
            3'b100: branch_taken = ~flag_carry;
            3'b101: branch_taken = flag_negative;
            3'b110: branch_taken = ~flag_negative;
            default: branch_taken = 1'b0;
        endcase
    end
endmodule

// File: tb/tb_alu_flags_unit.sv
// tb_alu_flags_unit: directed spec scenarios plus randomized traffic checked
// against a queue-based model of the flag register and snapshot stack.
module tb_alu_flags_unit;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic az = 0, ac = 0, an = 0, ld = 0, pu = 0, po = 0;
    logic [2:0] cs = 3'd0;
    logic fz, fc, fn, br, se, sf, serr;

    int n_tests = 0;
    int n_fail = 0;

    logic [2:0] m_flags;
    logic       m_err;
    logic [2:0] m_stack[$];

    alu_flags_unit #(.STACK_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .alu_zero_in(az), .alu_carry_in(ac), .alu_negative_in(an),
        .load_flags(ld), .flags_push(pu), .flags_pop(po), .cond_sel(cs),
        .flag_zero(fz), .flag_carry(fc), .flag_negative(fn),
        .branch_taken(br), .stack_empty(se), .stack_full(sf), .stack_error(serr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic m_branch(input logic [2:0] sel);
        logic [7:0] t;
        t = {1'b0, ~m_flags[2], m_flags[2], ~m_flags[1], m_flags[1], ~m_flags[0], m_flags[0], 1'b1};
        return t[sel];
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".flags"}, {29'd0, fn, fc, fz}, {29'd0, m_flags});
        chk({tag, ".empty"}, {31'd0, se}, {31'd0, m_stack.size() == 0});
        chk({tag, ".full"}, {31'd0, sf}, {31'd0, m_stack.size() == DEPTH});
        chk({tag, ".err"}, {31'd0, serr}, {31'd0, m_err});
        chk({tag, ".br"}, {31'd0, br}, {31'd0, m_branch(cs)});
    endtask

    task automatic model_clear();
        m_flags = 3'b000;
        m_err = 1'b0;
        m_stack.delete();
    endtask

    // one clock with the given inputs; {n,c,z} packs the ALU flags
    task automatic cyc(input string tag, input logic [2:0] alu, input logic l, input logic p,
                       input logic q, input logic [2:0] sel);
        logic popped;
        {an, ac, az} = alu;
        ld = l; pu = p; po = q; cs = sel;
        @(posedge clk);
        popped = 1'b0;
        if (p && q) m_err = 1'b1;
        else if (p) begin
            if (m_stack.size() == DEPTH) m_err = 1'b1;
            else m_stack.push_back(m_flags);
        end else if (q) begin
            if (m_stack.size() == 0) m_err = 1'b1;
            else begin
                m_flags = m_stack.pop_back();
                popped = 1'b1;
            end
        end
        if (l && !popped) m_flags = alu;
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        #2 reset = 1'b0;
        #1 model_clear();
        check_all(tag);
        @(negedge clk) reset = 1'b1;
    endtask

    initial begin
        model_clear();
        @(negedge clk);
        @(negedge clk) reset = 1'b1;
        check_all("por");

        // capture and branch
        cyc("cap", 3'b011, 1, 0, 0, 3'b001);
        chk("cap.z", {31'd0, fz}, 32'd1);
        chk("cap.c", {31'd0, fc}, 32'd1);
        chk("cap.br001", {31'd0, br}, 32'd1);
        cyc("br100", 3'b000, 0, 0, 0, 3'b100);
        chk("br100.v", {31'd0, br}, 32'd0);
        cyc("br111", 3'b000, 0, 0, 0, 3'b111);
        chk("br111.v", {31'd0, br}, 32'd0);

        // LIFO round trip
        cyc("rt.ld1", 3'b100, 1, 0, 0, 3'b101);
        cyc("rt.ps1", 3'b000, 0, 1, 0, 3'b000);
        cyc("rt.ld2", 3'b011, 1, 0, 0, 3'b011);
        cyc("rt.ps2", 3'b000, 0, 1, 0, 3'b010);
        cyc("rt.ld3", 3'b000, 1, 0, 0, 3'b110);
        cyc("rt.pop1", 3'b000, 0, 0, 1, 3'b001);
        chk("rt.pop1.v", {29'd0, fn, fc, fz}, 32'h3);
        cyc("rt.pop2", 3'b000, 0, 0, 1, 3'b101);
        chk("rt.pop2.v", {29'd0, fn, fc, fz}, 32'h4);
        chk("rt.empty", {31'd0, se}, 32'd1);
        chk("rt.noerr", {31'd0, serr}, 32'd0);

        // overflow
        do_reset("ovf.rst");
        cyc("ovf.ld", 3'b101, 1, 0, 0, 3'b000);
        for (int i = 0; i < DEPTH; i++) cyc("ovf.push", 3'(i), 0, 1, 0, 3'(i));
        chk("ovf.full", {31'd0, sf}, 32'd1);
        cyc("ovf.extra", 3'b010, 0, 1, 0, 3'b101);
        chk("ovf.err", {31'd0, serr}, 32'd1);
        chk("ovf.still_full", {31'd0, sf}, 32'd1);
        chk("ovf.flags", {29'd0, fn, fc, fz}, 32'h5);

        // underflow
        do_reset("udf.rst");
        cyc("udf.pop", 3'b000, 0, 0, 1, 3'b000);
        chk("udf.err", {31'd0, serr}, 32'd1);

        // simultaneous events
        do_reset("sim.rst");
        cyc("sim.ld", 3'b001, 1, 0, 0, 3'b000);
        cyc("sim.pushld", 3'b110, 1, 1, 0, 3'b101);
        chk("sim.pushld.v", {29'd0, fn, fc, fz}, 32'h6);
        cyc("sim.top", 3'b000, 0, 0, 1, 3'b001);
        chk("sim.top.v", {29'd0, fn, fc, fz}, 32'h1);
        cyc("sim.ld2", 3'b010, 1, 0, 0, 3'b000);
        cyc("sim.push2", 3'b000, 0, 1, 0, 3'b000);
        cyc("sim.popld", 3'b101, 1, 0, 1, 3'b011);
        chk("sim.popld.v", {29'd0, fn, fc, fz}, 32'h2);
        cyc("sim.push3", 3'b000, 0, 1, 0, 3'b000);
        cyc("sim.pp", 3'b000, 0, 1, 1, 3'b000);
        chk("sim.pp.err", {31'd0, serr}, 32'd1);
        chk("sim.pp.empty", {31'd0, se}, 32'd0);
        cyc("sim.pp.pop", 3'b000, 0, 0, 1, 3'b000);
        chk("sim.pp.count1", {31'd0, se}, 32'd1);

        // mid-run reset with count=2 and flags=111
        do_reset("mid.pre");
        cyc("mid.ld", 3'b111, 1, 1, 0, 3'b000);
        cyc("mid.push", 3'b111, 0, 1, 0, 3'b000);
        chk("mid.flags", {29'd0, fn, fc, fz}, 32'h7);
        do_reset("mid.rst");
        chk("mid.rst.empty", {31'd0, se}, 32'd1);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 79) == 0) do_reset("rnd.rst");
            cyc("rnd", 3'($urandom), $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
                $urandom_range(0, 2) == 0, 3'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
